mem_bus_arbiter: RTL and testbench

- Sequences the single RAM port between the instruction-fetch requester (imem side) and the data requester (dmem side) of the pipelined datapath.
- Sits between the datapath/cache interfaces and the RAM model.
- Registered grant FSM with data priority and an anti-starvation counter so fetch always progresses.
- Handles RAM BUSY/ERROR states by holding the grant and retrying.

---
 rtl/cpu_types_pkg.sv | 18 +
 rtl/arb_starve_counter.sv | 24 ++
 rtl/mem_bus_arbiter.sv | 113 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared datapath/memory types: RAM handshake states and bus arbiter FSM states.
// arb_state_t encoding doubles as the external gnt code.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERV_I = 2'd1,
        SERV_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of data completions won while fetch waits; clear dominates increment.
module arb_starve_counter #(
    parameter int LIMIT = 4,
    parameter int CW    = $clog2(LIMIT + 1)
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          at_limit
);

    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)                      cnt <= '0;
        else if (clr)                   cnt <= '0;
        else if (inc && (cnt != LIM))   cnt <= cnt + 1'b1;
    end

    assign at_limit = (cnt == LIM);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Grant is registered; RAM request and completion signals are forwarded live from the granted side.
module mem_bus_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ERRCNT_W     = 8
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                iREN,
    input  logic [31:0]         iaddr,
    output logic                iwait,
    output logic [31:0]         iload,
    input  logic                dREN,
    input  logic                dWEN,
    input  logic [31:0]         daddr,
    input  logic [31:0]         dstore,
    output logic                dwait,
    output logic [31:0]         dload,
    output logic                ramREN,
    output logic                ramWEN,
    output logic [31:0]         ramaddr,
    output logic [31:0]         ramstore,
    input  logic [31:0]         ramload,
    input  logic [1:0]          ramstate,
    output logic [1:0]          gnt,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam int SCW = $clog2(STARVE_LIMIT + 1);

    arb_state_t     state;
    ramstate_t      rs;
    logic           d_pend;
    logic           i_live, d_live;
    logic           i_done, d_done;
    logic           err_hit;
    logic           starve_lim;
    logic [SCW-1:0] starve_cnt;
    logic [31:0]    iload_q, dload_q;

    assign rs      = ramstate_t'(ramstate);
    assign d_pend  = dREN | dWEN;
    assign i_live  = (state == SERV_I) && iREN;
    assign d_live  = (state == SERV_D) && d_pend;
    assign i_done  = i_live && (rs == ACCESS);
    assign d_done  = d_live && (rs == ACCESS);
    assign err_hit = (i_live || d_live) && (rs == ERROR);
    assign gnt     = state;

    arb_starve_counter #(.LIMIT(STARVE_LIMIT), .CW(SCW)) u_starve (
        .CLK      (CLK),
        .nRST     (nRST),
        .inc      (d_done && iREN),
        .clr      (i_done || ((state == IDLE) && !iREN)),
        .cnt      (starve_cnt),
        .at_limit (starve_lim)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            iload_q   <= '0;
            dload_q   <= '0;
            err_count <= '0;
        end else begin
            if (i_done) iload_q <= ramload;
            if (d_done) dload_q <= ramload;
            if (err_hit && (err_count != '1)) err_count <= err_count + 1'b1;
            case (state)
                IDLE: begin
                    if (d_pend && !(iREN && starve_lim)) state <= SERV_D;
                    else if (iREN)                      state <= SERV_I;
                end
                // a dropped request is a flush: leave without completing
                SERV_I: if (!iREN || i_done)   state <= IDLE;
                SERV_D: if (!d_pend || d_done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iload    = iload_q;
        dload    = dload_q;
        if (i_live) begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
        end
        if (d_live) begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
        end
        if (i_done) begin
            iwait = 1'b0;
            iload = ramload;
        end
        if (d_done) begin
            dwait = 1'b0;
            dload = ramload;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a transaction-level reference model checked every cycle.
module tb_mem_bus_arbiter;

    localparam int LIM = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic [1:0]  gnt;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;
    bit run = 0;

    mem_bus_arbiter #(.STARVE_LIMIT(LIM), .ERRCNT_W(8)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate),
        .gnt(gnt), .err_count(err_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: owner 0 none, 1 fetch, 2 data
    int          m_own, m_starve, m_err;
    logic [31:0] m_il, m_dl;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_own = 0; m_starve = 0; m_err = 0; m_il = 0; m_dl = 0;
        end else begin
            case (m_own)
                0: begin
                    if (!iREN) m_starve = 0;
                    if ((dREN || dWEN) && !(iREN && m_starve == LIM)) m_own = 2;
                    else if (iREN) m_own = 1;
                end
                1: begin
                    if (!iREN) m_own = 0;
                    else if (ramstate == 2) begin m_il = ramload; m_starve = 0; m_own = 0; end
                    else if (ramstate == 3 && m_err < 255) m_err++;
                end
                default: begin
                    if (!(dREN || dWEN)) m_own = 0;
                    else if (ramstate == 2) begin
                        m_dl = ramload;
                        if (iREN && m_starve < LIM) m_starve++;
                        m_own = 0;
                    end else if (ramstate == 3 && m_err < 255) m_err++;
                end
            endcase
        end
    end

    always @(negedge CLK) begin
        if (nRST && run) begin
            logic        e_iw, e_dw, e_ren, e_wen;
            logic [31:0] e_addr, e_st, e_il, e_dl;
            e_iw = 1; e_dw = 1; e_ren = 0; e_wen = 0; e_addr = 0; e_st = 0;
            e_il = m_il; e_dl = m_dl;
            if (m_own == 1 && iREN) begin
                e_ren = 1; e_addr = iaddr;
                if (ramstate == 2) begin e_iw = 0; e_il = ramload; end
            end
            if (m_own == 2 && (dREN || dWEN)) begin
                e_addr = daddr; e_st = dstore; e_wen = dWEN; e_ren = dREN && !dWEN;
                if (ramstate == 2) begin e_dw = 0; e_dl = ramload; end
            end
            chk("gnt", gnt, m_own);
            chk("iwait", iwait, e_iw);
            chk("dwait", dwait, e_dw);
            chk("ramREN", ramREN, e_ren);
            chk("ramWEN", ramWEN, e_wen);
            chk("ramaddr", ramaddr, e_addr);
            chk("ramstore", ramstore, e_st);
            chk("iload", iload, e_il);
            chk("dload", dload, e_dl);
            chk("err_count", err_count, m_err);
            chk("starve_cnt", dut.starve_cnt, m_starve);
        end
    end

    task automatic cyc();
        @(posedge CLK); #1;
    endtask

    task automatic neg();
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        iREN = 0; dREN = 0; dWEN = 0; ramstate = 2'd0;
    endtask

    int exp_gnt [11] = '{0, 2, 0, 2, 0, 2, 0, 2, 0, 1, 0};

    initial begin
        nRST = 0; idle_inputs();
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
        #3;
        chk("rst_gnt", gnt, 0);
        chk("rst_iwait", iwait, 1);
        chk("rst_dwait", dwait, 1);
        chk("rst_ramREN", ramREN, 0);
        chk("rst_ramWEN", ramWEN, 0);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_loads", {iload[15:0], dload[15:0]}, 0);
        chk("rst_err", err_count, 0);
        @(posedge CLK); #1; nRST = 1; run = 1;

        // Fetch alone, two BUSY cycles then ACCESS
        cyc(); iREN = 1; iaddr = 32'h40; ramstate = 2'd1; ramload = 32'h8C220004;
        cyc(); neg();
        chk("t1_gnt", gnt, 1); chk("t1_ren", ramREN, 1); chk("t1_addr", ramaddr, 32'h40);
        chk("t1_iwait_busy", iwait, 1);
        cyc();
        cyc(); ramstate = 2'd2; neg();
        chk("t1_iwait", iwait, 0); chk("t1_iload", iload, 32'h8C220004);
        cyc(); iREN = 0; ramstate = 2'd0; neg();
        chk("t1_gnt_after", gnt, 0); chk("t1_iload_hold", iload, 32'h8C220004);

        // Simultaneous fetch and write (with dREN too): data first, write wins
        cyc(); iREN = 1; iaddr = 32'h44; dWEN = 1; dREN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        cyc(); neg();
        chk("t2_gnt", gnt, 2); chk("t2_wen", ramWEN, 1); chk("t2_ren", ramREN, 0);
        chk("t2_addr", ramaddr, 32'h100); chk("t2_store", ramstore, 32'hDEADBEEF);
        cyc(); ramstate = 2'd2; ramload = 32'h0; neg();
        chk("t2_dwait", dwait, 0);
        cyc(); dWEN = 0; dREN = 0; ramstate = 2'd0; neg();
        chk("t2_bubble", gnt, 0);
        cyc(); ramstate = 2'd2; ramload = 32'h24020001; neg();
        chk("t2_gnt_i", gnt, 1); chk("t2_iaddr", ramaddr, 32'h44); chk("t2_iwait", iwait, 0);
        cyc(); iREN = 0; ramstate = 2'd0;

        // Starvation: data continuously pending with fetch waiting
        cyc(); iREN = 1; dREN = 1; iaddr = 32'h48; daddr = 32'h200; ramstate = 2'd2; ramload = 32'h11110000;
        for (int k = 0; k < 11; k++) begin
            neg();
            chk($sformatf("t3_gnt%0d", k), gnt, exp_gnt[k]);
            if (k == 8)  chk("t3_starve_lim", dut.starve_cnt, LIM);
            if (k == 10) chk("t3_starve_clr", dut.starve_cnt, 0);
            cyc();
        end
        dREN = 0; iREN = 0; ramstate = 2'd0;
        cyc(); cyc();

        // ERROR retries then ACCESS
        dREN = 1; daddr = 32'h300; ramstate = 2'd3;
        cyc(); neg();
        chk("t4_dwait_err", dwait, 1); chk("t4_ren", ramREN, 1); chk("t4_addr", ramaddr, 32'h300);
        cyc(); cyc();
        cyc(); ramstate = 2'd2; ramload = 32'hCAFEF00D; neg();
        chk("t4_err3", err_count, 3); chk("t4_dwait", dwait, 0); chk("t4_dload", dload, 32'hCAFEF00D);
        cyc(); dREN = 0; ramstate = 2'd0;

        // Fetch flushed before ACCESS, data then granted
        cyc(); iREN = 1; iaddr = 32'h50; ramstate = 2'd1;
        cyc(); neg(); chk("t5_gnt_i", gnt, 1);
        cyc(); iREN = 0; dREN = 1; daddr = 32'h400; #1;
        chk("t5_abort_ren", ramREN, 0); chk("t5_abort_iwait", iwait, 1);
        cyc(); neg(); chk("t5_gnt_idle", gnt, 0); chk("t5_ren_idle", ramREN, 0);
        cyc(); neg(); chk("t5_gnt_d", gnt, 2); chk("t5_ren_d", ramREN, 1);

        // Asynchronous reset during a data write
        dWEN = 1; dstore = 32'h12345678; #1;
        chk("t6_wen_pre", ramWEN, 1);
        #1 nRST = 0; #1;
        chk("t6_wen", ramWEN, 0); chk("t6_gnt", gnt, 0); chk("t6_dwait", dwait, 1);
        chk("t6_err", err_count, 0); chk("t6_starve", dut.starve_cnt, 0);
        cyc(); idle_inputs(); nRST = 1;

        // Error counter saturation
        cyc(); dREN = 1; daddr = 32'h500; ramstate = 2'd3;
        repeat (262) cyc();
        neg(); chk("t7_err_sat", err_count, 255); chk("t7_dwait", dwait, 1);
        cyc(); ramstate = 2'd2; ramload = 32'h55AA55AA; neg();
        chk("t7_dwait_done", dwait, 0); chk("t7_err_hold", err_count, 255);
        cyc(); idle_inputs();
        cyc(); cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
